// File: rtl/wm_pkg.sv
// wm_pkg: shared definitions for the watermark raster writer.
//   DATA_DEPTH / ADDR_WIDTH / DIM_WIDTH : default widths for pixel, frame RAM
//                                         address and image-side fields
//   MAX_IMG_SIZE / MAX_BLOCK_SIDE       : largest supported Np and M
//   state_t                             : writer frame state
package wm_pkg;

    localparam int DATA_DEPTH     = 8;
    localparam int ADDR_WIDTH     = 20;
    localparam int DIM_WIDTH      = 10;
    localparam int MAX_IMG_SIZE   = 720;
    localparam int MAX_BLOCK_SIDE = 72;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/wm_block_addr_gen.sv
// wm_block_addr_gen: walks an Np x Np image in M x M block order and presents
// the raster address (row*Np + col) of the current pixel.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the walk at address 0
//   step     : advance to the next pixel
//   np, m    : image side and block side (held stable during a frame)
//   addr     : raster address of the current pixel
module wm_block_addr_gen
    import wm_pkg::*;
#(
    parameter int Data_Depth = DATA_DEPTH,
    parameter int Addr_Width = ADDR_WIDTH,
    parameter int Dim_Width  = DIM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  step,
    input  logic [Dim_Width-1:0]  np,
    input  logic [Data_Depth-1:0] m,
    output logic [Addr_Width-1:0] addr
);

    logic [Data_Depth-1:0] col;
    logic [Data_Depth-1:0] row;
    logic [Dim_Width-1:0]  bx;
    logic [Addr_Width-1:0] line_ptr;
    logic [Addr_Width-1:0] blk_origin;

    logic [Data_Depth-1:0] col_nx;
    logic [Data_Depth-1:0] row_nx;
    logic [Dim_Width-1:0]  bx_nx;
    logic [Addr_Width-1:0] np_a;
    logic [Addr_Width-1:0] m_a;

    assign col_nx = col + Data_Depth'(1);
    assign row_nx = row + Data_Depth'(1);
    assign bx_nx  = bx + Dim_Width'(m);
    assign np_a   = Addr_Width'(np);
    assign m_a    = Addr_Width'(m);
    assign addr   = line_ptr + Addr_Width'(col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            bx         <= '0;
            line_ptr   <= '0;
            blk_origin <= '0;
        end else if (clear) begin
            col        <= '0;
            row        <= '0;
            bx         <= '0;
            line_ptr   <= '0;
            blk_origin <= '0;
        end else if (step) begin
            if (col_nx == m) begin
                col <= '0;
                if (row_nx == m) begin
                    row <= '0;
                    if (bx_nx == np) begin
                        // Last block of a strip: line_ptr sits on the block's
                        // last row at origin (Np-M), so line_ptr + M equals
                        // strip origin + Np*M without a multiplier.
                        bx         <= '0;
                        blk_origin <= line_ptr + m_a;
                        line_ptr   <= line_ptr + m_a;
                    end else begin
                        bx         <= bx_nx;
                        blk_origin <= blk_origin + m_a;
                        line_ptr   <= blk_origin + m_a;
                    end
                end else begin
                    row      <= row_nx;
                    line_ptr <= line_ptr + np_a;
                end
            end else begin
                col <= col_nx;
            end
        end
    end

endmodule

// File: rtl/wm_raster_writer.sv
// wm_raster_writer: converts the watermarking core's block-ordered pixel
// stream into raster-addressed frame RAM writes and closes the frame.
//   clk, rst              : clock, asynchronous active-high reset
//   cfg_load, cfg_Np/M    : latch image/block side and arm a new frame
//   Pixel_Data, new_pixel : pixel stream, one pixel per new_pixel rising edge
//   Image_Done            : rising edge ends the frame
//   wr_en/wr_addr/wr_data : one-cycle frame RAM write per accepted pixel
//   frame_done            : one-cycle pulse at frame close
//   pixel_count           : pixels accepted this frame
//   err_overrun/err_short : sticky error flags, cleared on cfg_load
//   checksum              : sum of written pixels (only with WM_CHECKSUM_EN)
module wm_raster_writer
    import wm_pkg::*;
#(
    parameter int Data_Depth = DATA_DEPTH,
    parameter int Addr_Width = ADDR_WIDTH,
    parameter int Dim_Width  = DIM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_load,
    input  logic [Dim_Width-1:0]  cfg_Np,
    input  logic [Data_Depth-1:0] cfg_M,
    input  logic [Data_Depth-1:0] Pixel_Data,
    input  logic                  new_pixel,
    input  logic                  Image_Done,
    output logic                  wr_en,
    output logic [Addr_Width-1:0] wr_addr,
    output logic [Data_Depth-1:0] wr_data,
    output logic                  frame_done,
    output logic [Addr_Width-1:0] pixel_count,
    output logic                  err_overrun,
    output logic                  err_short
`ifdef WM_CHECKSUM_EN
    ,
    output logic [27:0]           checksum
`endif
);

    state_t                state;
    logic [Dim_Width-1:0]  np_reg;
    logic [Data_Depth-1:0] m_reg;
    logic [Addr_Width-1:0] total;

    logic                  np_q, np_prev;
    logic                  id_q, id_prev;
    logic [Data_Depth-1:0] pix_q;

    logic                  pix_rise;
    logic                  done_rise;
    logic                  accept;
    logic                  last_pix;
    logic [Addr_Width-1:0] count_inc;
    logic [Addr_Width-1:0] cfg_np_ext;
    logic [Addr_Width-1:0] gen_addr;

    assign pix_rise   = np_q & ~np_prev;
    assign done_rise  = id_q & ~id_prev;
    assign count_inc  = pixel_count + Addr_Width'(1);
    assign cfg_np_ext = Addr_Width'(cfg_Np);
    assign accept     = !cfg_load && pix_rise && (state == RUN) && (pixel_count != total);
    assign last_pix   = accept && (count_inc == total);

    wm_block_addr_gen #(
        .Data_Depth (Data_Depth),
        .Addr_Width (Addr_Width),
        .Dim_Width  (Dim_Width)
    ) u_addr_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (cfg_load),
        .step  (accept),
        .np    (np_reg),
        .m     (m_reg),
        .addr  (gen_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            np_reg      <= '0;
            m_reg       <= '0;
            total       <= '0;
            np_q        <= 1'b0;
            np_prev     <= 1'b0;
            id_q        <= 1'b0;
            id_prev     <= 1'b0;
            pix_q       <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            pixel_count <= '0;
            err_overrun <= 1'b0;
            err_short   <= 1'b0;
`ifdef WM_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            np_q       <= new_pixel;
            np_prev    <= np_q;
            id_q       <= Image_Done;
            id_prev    <= id_q;
            pix_q      <= Pixel_Data;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            if (cfg_load) begin
                state       <= RUN;
                np_reg      <= cfg_Np;
                m_reg       <= cfg_M;
                total       <= cfg_np_ext * cfg_np_ext;
                pixel_count <= '0;
                err_overrun <= 1'b0;
                err_short   <= 1'b0;
`ifdef WM_CHECKSUM_EN
                checksum    <= '0;
`endif
            end else begin
                if (accept) begin
                    wr_en       <= 1'b1;
                    wr_addr     <= gen_addr;
                    wr_data     <= pix_q;
                    pixel_count <= count_inc;
`ifdef WM_CHECKSUM_EN
                    checksum    <= checksum + 28'(pix_q);
`endif
                    if (last_pix) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end else if (pix_rise) begin
                    err_overrun <= 1'b1;
                end

                // A same-cycle pixel is counted before the short check; a frame
                // already closed by reaching total ignores Image_Done.
                if (done_rise && (state == RUN) && !last_pix) begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                    if ((accept ? count_inc : pixel_count) != total)
                        err_short <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wm_raster_writer.sv
module tb_wm_raster_writer;

    logic        clk;
    logic        rst;
    logic        cfg_load;
    logic [9:0]  cfg_Np;
    logic [7:0]  cfg_M;
    logic [7:0]  Pixel_Data;
    logic        new_pixel;
    logic        Image_Done;
    logic        wr_en;
    logic [19:0] wr_addr;
    logic [7:0]  wr_data;
    logic        frame_done;
    logic [19:0] pixel_count;
    logic        err_overrun;
    logic        err_short;
`ifdef WM_CHECKSUM_EN
    logic [27:0] checksum;
`endif

    int vectors;
    int miscompares;

    // write monitor state
    int          wr_cnt;
    int          fd_cnt;
    logic        fd_on_wr;
    logic [19:0] addr_log [int];
    logic [7:0]  ram [int];

    wm_raster_writer dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_Np      (cfg_Np),
        .cfg_M       (cfg_M),
        .Pixel_Data  (Pixel_Data),
        .new_pixel   (new_pixel),
        .Image_Done  (Image_Done),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .pixel_count (pixel_count),
        .err_overrun (err_overrun),
        .err_short   (err_short)
`ifdef WM_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            addr_log[wr_cnt] = wr_addr;
            ram[int'(wr_addr)] = wr_data;
            wr_cnt = wr_cnt + 1;
        end
        if (frame_done === 1'b1) begin
            fd_cnt   = fd_cnt + 1;
            fd_on_wr = wr_en;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic do_cfg(input int np, input int m);
        @(posedge clk); #1;
        cfg_Np   = 10'(np);
        cfg_M    = 8'(m);
        cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    task automatic send_pixel(input int v, input int width);
        @(posedge clk); #1;
        new_pixel  = 1'b1;
        Pixel_Data = 8'(v);
        repeat (width) @(posedge clk);
        #1;
        new_pixel  = 1'b0;
    endtask

    task automatic send_pixel_done(input int v);
        @(posedge clk); #1;
        new_pixel  = 1'b1;
        Image_Done = 1'b1;
        Pixel_Data = 8'(v);
        @(posedge clk); #1;
        new_pixel  = 1'b0;
        Image_Done = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        Image_Done = 1'b1;
        @(posedge clk); #1;
        Image_Done = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %b need 0", wr_en); end
        vectors++;
        if (wr_addr !== 20'd0) begin miscompares++; $display("FAIL reset_wr_addr got %0d need 0", wr_addr); end
        vectors++;
        if (wr_data !== 8'd0) begin miscompares++; $display("FAIL reset_wr_data got %0d need 0", wr_data); end
        vectors++;
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got %b need 0", frame_done); end
        vectors++;
        if (pixel_count !== 20'd0) begin miscompares++; $display("FAIL reset_pixel_count got %0d need 0", pixel_count); end
        vectors++;
        if ({err_overrun, err_short} !== 2'b00) begin miscompares++; $display("FAIL reset_errors got %b need 00", {err_overrun, err_short}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_pixel();
        int base;
        base = wr_cnt;
        send_pixel(42, 1);
        settle();
        vectors++;
        if (wr_cnt - base !== 0) begin miscompares++; $display("FAIL idle_no_write got %0d writes need 0", wr_cnt - base); end
        vectors++;
        if (err_overrun !== 1'b1) begin miscompares++; $display("FAIL idle_overrun got %b need 1", err_overrun); end
    endtask

    task automatic test_basic();
        int base, fd0;
        int exp_a [36] = '{0, 1, 2, 6, 7, 8, 12, 13, 14,
                           3, 4, 5, 9, 10, 11, 15, 16, 17,
                           18, 19, 20, 24, 25, 26, 30, 31, 32,
                           21, 22, 23, 27, 28, 29, 33, 34, 35};
        do_cfg(6, 3);
        vectors++;
        if (err_overrun !== 1'b0) begin miscompares++; $display("FAIL cfg_clears_overrun got %b need 0", err_overrun); end
        base = wr_cnt;
        fd0  = fd_cnt;
        for (int i = 0; i < 36; i++) send_pixel(i, 1);
        settle();
        vectors++;
        if (wr_cnt - base !== 36) begin miscompares++; $display("FAIL basic_writes got %0d need 36", wr_cnt - base); end
        for (int i = 0; i < 36; i++) begin
            vectors++;
            if (addr_log[base + i] !== 20'(exp_a[i])) begin
                miscompares++;
                $display("FAIL basic_addr[%0d] got %0d need %0d", i, addr_log[base + i], exp_a[i]);
            end
        end
        vectors++;
        if (ram[3] !== 8'd9) begin miscompares++; $display("FAIL basic_ram3 got %0d need 9", ram[3]); end
        vectors++;
        if (ram[18] !== 8'd18) begin miscompares++; $display("FAIL basic_ram18 got %0d need 18", ram[18]); end
        vectors++;
        if (pixel_count !== 20'd36) begin miscompares++; $display("FAIL basic_count got %0d need 36", pixel_count); end
        vectors++;
        if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL basic_frame_done got %0d pulses need 1", fd_cnt - fd0); end
        vectors++;
        if (fd_on_wr !== 1'b1) begin miscompares++; $display("FAIL basic_fd_with_last_wr got %b need 1", fd_on_wr); end
        vectors++;
        if ({err_overrun, err_short} !== 2'b00) begin miscompares++; $display("FAIL basic_errors got %b need 00", {err_overrun, err_short}); end
`ifdef WM_CHECKSUM_EN
        vectors++;
        if (checksum !== 28'd630) begin miscompares++; $display("FAIL basic_checksum got %0d need 630", checksum); end
`endif
        // Image_Done after the count already closed the frame is ignored
        pulse_done();
        settle();
        vectors++;
        if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL late_done_ignored got %0d pulses need 1", fd_cnt - fd0); end
        vectors++;
        if (err_short !== 1'b0) begin miscompares++; $display("FAIL late_done_short got %b need 0", err_short); end
    endtask

    task automatic test_overrun();
        int base;
        base = wr_cnt;
        send_pixel(99, 1);
        settle();
        vectors++;
        if (wr_cnt - base !== 0) begin miscompares++; $display("FAIL overrun_no_write got %0d writes need 0", wr_cnt - base); end
        vectors++;
        if (err_overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_flag got %b need 1", err_overrun); end
        vectors++;
        if (pixel_count !== 20'd36) begin miscompares++; $display("FAIL overrun_count got %0d need 36", pixel_count); end
        do_cfg(6, 3);
        vectors++;
        if (err_overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_cleared got %b need 0", err_overrun); end
        vectors++;
        if (pixel_count !== 20'd0) begin miscompares++; $display("FAIL overrun_count_cleared got %0d need 0", pixel_count); end
    endtask

    task automatic test_short_frame();
        int base, fd0;
        int idx [4] = '{2, 4, 12, 19};
        int exp_a [4] = '{6, 2, 12, 21};
        do_cfg(6, 2);
        base = wr_cnt;
        fd0  = fd_cnt;
        for (int i = 0; i < 20; i++) send_pixel(i + 100, 1);
        settle();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (addr_log[base + idx[i]] !== 20'(exp_a[i])) begin
                miscompares++;
                $display("FAIL short_addr[%0d] got %0d need %0d", idx[i], addr_log[base + idx[i]], exp_a[i]);
            end
        end
        vectors++;
        if (fd_cnt - fd0 !== 0) begin miscompares++; $display("FAIL short_early_fd got %0d pulses need 0", fd_cnt - fd0); end
        pulse_done();
        settle();
        vectors++;
        if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL short_frame_done got %0d pulses need 1", fd_cnt - fd0); end
        vectors++;
        if (err_short !== 1'b1) begin miscompares++; $display("FAIL short_err got %b need 1", err_short); end
        vectors++;
        if (pixel_count !== 20'd20) begin miscompares++; $display("FAIL short_count got %0d need 20", pixel_count); end
    endtask

    task automatic test_done_with_pixel();
        int base, fd0;
        do_cfg(6, 3);
        vectors++;
        if (err_short !== 1'b0) begin miscompares++; $display("FAIL cfg_clears_short got %b need 0", err_short); end
        base = wr_cnt;
        fd0  = fd_cnt;
        for (int i = 0; i < 5; i++) send_pixel(i, 1);
        send_pixel_done(55);
        settle();
        vectors++;
        if (wr_cnt - base !== 6) begin miscompares++; $display("FAIL same_cycle_writes got %0d need 6", wr_cnt - base); end
        vectors++;
        if (addr_log[base + 5] !== 20'd8) begin miscompares++; $display("FAIL same_cycle_addr got %0d need 8", addr_log[base + 5]); end
        vectors++;
        if (ram[8] !== 8'd55) begin miscompares++; $display("FAIL same_cycle_data got %0d need 55", ram[8]); end
        vectors++;
        if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL same_cycle_fd got %0d pulses need 1", fd_cnt - fd0); end
        vectors++;
        if (fd_on_wr !== 1'b1) begin miscompares++; $display("FAIL same_cycle_fd_with_wr got %b need 1", fd_on_wr); end
        vectors++;
        if (err_short !== 1'b1) begin miscompares++; $display("FAIL same_cycle_short got %b need 1", err_short); end
        vectors++;
        if (pixel_count !== 20'd6) begin miscompares++; $display("FAIL same_cycle_count got %0d need 6", pixel_count); end
    endtask

    task automatic test_pulse_width();
        int base;
        do_cfg(6, 3);
        base = wr_cnt;
        send_pixel(7, 4);
        settle();
        vectors++;
        if (wr_cnt - base !== 1) begin miscompares++; $display("FAIL wide_pulse_writes got %0d need 1", wr_cnt - base); end
        vectors++;
        if (pixel_count !== 20'd1) begin miscompares++; $display("FAIL wide_pulse_count got %0d need 1", pixel_count); end
    endtask

    task automatic test_big_np();
        int base, fd0;
        int idx [5] = '{3, 8, 9, 2159, 2160};
        int exp_a [5] = '{720, 1442, 3, 2159, 2160};
        do_cfg(720, 3);
        base = wr_cnt;
        fd0  = fd_cnt;
        for (int i = 0; i < 2161; i++) send_pixel(i, 1);
        settle();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (addr_log[base + idx[i]] !== 20'(exp_a[i])) begin
                miscompares++;
                $display("FAIL np720_addr[%0d] got %0d need %0d", idx[i], addr_log[base + idx[i]], exp_a[i]);
            end
        end
        vectors++;
        if (pixel_count !== 20'd2161) begin miscompares++; $display("FAIL np720_count got %0d need 2161", pixel_count); end
        vectors++;
        if (fd_cnt - fd0 !== 0) begin miscompares++; $display("FAIL np720_no_fd got %0d pulses need 0", fd_cnt - fd0); end
    endtask

    task automatic test_full_frame();
        int base, fd0;
        do_cfg(120, 3);
        base = wr_cnt;
        fd0  = fd_cnt;
        for (int i = 0; i < 14400; i++) send_pixel(i % 256, 1);
        settle();
        vectors++;
        if (wr_cnt - base !== 14400) begin miscompares++; $display("FAIL full_writes got %0d need 14400", wr_cnt - base); end
        vectors++;
        if (addr_log[base + 14399] !== 20'd14399) begin miscompares++; $display("FAIL full_last_addr got %0d need 14399", addr_log[base + 14399]); end
        vectors++;
        if (pixel_count !== 20'd14400) begin miscompares++; $display("FAIL full_count got %0d need 14400", pixel_count); end
        vectors++;
        if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL full_fd got %0d pulses need 1", fd_cnt - fd0); end
        vectors++;
        if (fd_on_wr !== 1'b1) begin miscompares++; $display("FAIL full_fd_with_wr got %b need 1", fd_on_wr); end
        vectors++;
        if ({err_overrun, err_short} !== 2'b00) begin miscompares++; $display("FAIL full_errors got %b need 00", {err_overrun, err_short}); end
    endtask

    task automatic test_rst_mid_frame();
        int base;
        do_cfg(6, 3);
        base = wr_cnt;
        for (int i = 0; i < 10; i++) send_pixel(i + 10, 1);
        // tenth pixel is still in flight here and must be dropped
        rst = 1'b1;
        #1;
        vectors++;
        if ({wr_en, frame_done} !== 2'b00) begin miscompares++; $display("FAIL rst_strobes got %b need 00", {wr_en, frame_done}); end
        vectors++;
        if (pixel_count !== 20'd0) begin miscompares++; $display("FAIL rst_count got %0d need 0", pixel_count); end
        vectors++;
        if (wr_addr !== 20'd0) begin miscompares++; $display("FAIL rst_addr got %0d need 0", wr_addr); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (wr_cnt - base !== 9) begin miscompares++; $display("FAIL rst_partial_writes got %0d need 9", wr_cnt - base); end
        do_cfg(6, 3);
        send_pixel(77, 1);
        settle();
        vectors++;
        if (addr_log[base + 9] !== 20'd0) begin miscompares++; $display("FAIL rst_restart_addr got %0d need 0", addr_log[base + 9]); end
        vectors++;
        if (ram[0] !== 8'd77) begin miscompares++; $display("FAIL rst_restart_data got %0d need 77", ram[0]); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wr_cnt      = 0;
        fd_cnt      = 0;
        fd_on_wr    = 1'b0;
        rst         = 1'b1;
        cfg_load    = 1'b0;
        cfg_Np      = '0;
        cfg_M       = '0;
        Pixel_Data  = '0;
        new_pixel   = 1'b0;
        Image_Done  = 1'b0;

        test_reset();
        test_idle_pixel();
        test_basic();
        test_overrun();
        test_short_frame();
        test_done_with_pixel();
        test_pulse_width();
        test_big_np();
        test_full_frame();
        test_rst_mid_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
